uart_rx: RTL and testbench

Serial-to-parallel UART receiver, 8N1, LSB first, idle-high line; counterpart of the uart_tx transmitter.
- Synchronises the asynchronous rx pin and detects start bits.
- Samples every bit at mid-period and checks the stop bit.
- Presents each received byte on a one-entry valid/ready holding register to the bus-side consumer (MMIO UART peripheral).

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync.sv | 34 +++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver types and frame constants.
package uart_pkg;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLOCKS_PER_BAUD = 434;

  // 8N1 framing: eight data bits, LSB first.
  localparam int DATA_BITS = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input.
// RESET_VAL lets an idle-high line come out of reset without a false edge.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the pin through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser register chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-period,
// checks the stop bit and hands bytes to the consumer through a
// one-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF_BAUD = CLOCKS_PER_BAUD / 2;
  localparam int CNT_W     = $clog2(CLOCKS_PER_BAUD);
  localparam int BIT_W     = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BAUD - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 expired;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign expired = (cnt_q == '0);

  // Next-state, bit sampling and holding-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer handshake; a delivery below may re-assert valid.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end

      START: begin
        if (expired) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = '0;
          end else begin
            // Line went back high before mid-start: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DATA: begin
        if (expired) begin
          shift_d[bit_q] = rx_s;
          cnt_d          = FULL_LOAD;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STOP: begin
        if (expired) begin
          if (rx_s) begin
            state_d = IDLE;
            // A full register being drained this very cycle makes room.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WAIT_HIGH: begin
        // Hold off until a break ends so it cannot re-trigger frames.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shift and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised checks for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLOCKS_PER_BAUD(C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .ready    (ready),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: bytes the consumer should receive, in order, vs. bytes seen
  // crossing the valid/ready handshake.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int   fe_cycles = 0, fe_pulses = 0;
  int   ov_cycles = 0, ov_pulses = 0;
  int   both_cycles = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;

  // Observe handshakes and pulse activity on every falling edge.
  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(data);
    if (frame_err) fe_cycles++;
    if (frame_err && !fe_prev) fe_pulses++;
    if (overrun) ov_cycles++;
    if (overrun && !ov_prev) ov_pulses++;
    if (frame_err && overrun) both_cycles++;
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Input drive point: just after the rising edge.
  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) drv_edge();
  endtask

  // Output sample point: just after the falling edge, after the monitor.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // One 8N1 frame, LSB first; line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [7:0] v;
    v  = b;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      tick(C);
    end
    rx = stop;
    tick(C);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      settle();
      n++;
    end while (!valid && n < 400);
  endtask

  task automatic check_queue(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int fe_base, ov_base, fe_exp;
    logic [7:0] b;
    logic       bad;
    logic       rdone;

    // Reset state.
    tick(3);
    settle();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    drv_edge();
    rst_n = 1'b1;
    tick(4);

    // 1: clean 0xA5 with ready high.
    ready   = 1'b1;
    fe_base = fe_pulses;
    ov_base = ov_pulses;
    drv_edge();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        // 2 sync stages + IDLE decision edge + HALF_BAUD + 9 bit periods,
        // first seen at the falling edge after that rising edge.
        wait_valid(n);
        chk("t1_latency", 32'(n), 32'(2 + 1 + H + 9 * C + 1));
        chk("t1_data", 32'(data), 32'h A5);
        chk("t1_busy_after_stop", 32'(busy), 0);
        settle();
        chk("t1_valid_width", 32'(valid), 0);
      end
      begin
        repeat (5 * C) settle();
        chk("t1_busy_mid", 32'(busy), 1);
      end
    join
    exp_q.push_back(8'hA5);
    tick(2);
    check_queue("t1_bytes");
    chk("t1_frame_err", 32'(fe_pulses - fe_base), 0);
    chk("t1_overrun", 32'(ov_pulses - ov_base), 0);

    // 2: 0x00 then 0xFF back-to-back with nothing draining.
    ready   = 1'b0;
    ov_base = ov_pulses;
    fe_base = fe_pulses;
    drv_edge();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(3);
    settle();
    chk("t2_valid_held", 32'(valid), 1);
    chk("t2_data_held", 32'(data), 32'h00);
    chk("t2_overrun", 32'(ov_pulses - ov_base), 1);
    chk("t2_frame_err", 32'(fe_pulses - fe_base), 0);
    drv_edge();
    ready = 1'b1;
    drv_edge();
    ready = 1'b0;
    settle();
    chk("t2_drained", 32'(valid), 0);
    exp_q.push_back(8'h00);
    check_queue("t2_bytes");

    // 3: 4-cycle low glitch while idle.
    fe_base = fe_pulses;
    drv_edge();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3);
    settle();
    chk("t3_busy_in_start", 32'(busy), 1);
    tick(2 * C);
    settle();
    chk("t3_busy_idle", 32'(busy), 0);
    chk("t3_valid", 32'(valid), 0);
    chk("t3_frame_err", 32'(fe_pulses - fe_base), 0);

    // 4: bad stop bit then a 40-bit break, then a good 0x81.
    ready   = 1'b1;
    fe_base = fe_pulses;
    drv_edge();
    send_frame(8'h3C, 1'b0);
    tick(40 * C);
    settle();
    chk("t4_frame_err", 32'(fe_pulses - fe_base), 1);
    chk("t4_busy_break", 32'(busy), 1);
    chk("t4_valid", 32'(valid), 0);
    chk("t4_no_bytes", 32'(got_q.size()), 0);
    drv_edge();
    rx = 1'b1;
    tick(2 * C);
    settle();
    chk("t4_busy_released", 32'(busy), 0);
    drv_edge();
    send_frame(8'h81, 1'b1);
    tick(5);
    exp_q.push_back(8'h81);
    check_queue("t4_bytes");
    chk("t4_frame_err_total", 32'(fe_pulses - fe_base), 1);

    // 5: register full with 0x11; ready rises exactly as 0x22 delivers.
    ready   = 1'b0;
    ov_base = ov_pulses;
    drv_edge();
    send_frame(8'h11, 1'b1);
    tick(3);
    settle();
    chk("t5_first_held", 32'(data), 32'h11);
    drv_edge();
    fork
      send_frame(8'h22, 1'b1);
      begin
        // Delivery edge is the 155th rising edge after the start bit.
        repeat (2 + 1 + H + 9 * C - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    settle();
    chk("t5_valid", 32'(valid), 1);
    chk("t5_data", 32'(data), 32'h22);
    chk("t5_overrun", 32'(ov_pulses - ov_base), 0);
    exp_q.push_back(8'h11);
    check_queue("t5_bytes");

    // 6: reset during data bit 4, then 0x5A.
    fe_base = fe_pulses;
    ov_base = ov_pulses;
    b = 8'hC3;
    drv_edge();
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = b[4];
    tick(H);
    rst_n = 1'b0;
    rx    = 1'b1;
    settle();
    chk("t6_rst_valid", 32'(valid), 0);
    chk("t6_rst_data", 32'(data), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_frame_err", 32'(frame_err), 0);
    chk("t6_rst_overrun", 32'(overrun), 0);
    tick(4);
    rst_n = 1'b1;
    tick(2 * C);
    settle();
    chk("t6_idle_after", 32'(busy), 0);
    drv_edge();
    ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    tick(5);
    exp_q.push_back(8'h5A);
    check_queue("t6_bytes");
    chk("t6_no_pulses", 32'((fe_pulses - fe_base) + (ov_pulses - ov_base)), 0);

    // Random frames, some with a bad stop bit, random ready pattern.
    fe_base = fe_pulses;
    ov_base = ov_pulses;
    fe_exp  = 0;
    rdone   = 1'b0;
    drv_edge();
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          b   = 8'($urandom_range(0, 255));
          bad = ($urandom_range(0, 3) == 0);
          send_frame(b, !bad);
          if (bad) begin
            fe_exp++;
            rx = 1'b1;
            tick(2 * C);
          end else begin
            exp_q.push_back(b);
          end
          tick($urandom_range(0, 3));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          drv_edge();
          ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ready = 1'b1;
    tick(4);
    check_queue("rand_bytes");
    chk("rand_frame_err", 32'(fe_pulses - fe_base), 32'(fe_exp));
    chk("rand_overrun", 32'(ov_pulses - ov_base), 0);

    // Pulse shape over the whole run.
    chk("frame_err_one_cycle", 32'(fe_cycles), 32'(fe_pulses));
    chk("overrun_one_cycle", 32'(ov_cycles), 32'(ov_pulses));
    chk("pulses_exclusive", 32'(both_cycles), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
